instr_fetch_stage: RTL and testbench
====================================

# instr_fetch_stage

Fetch stage of the 16-bit pipeline. Owns the program counter and drives the instruction memory address. Registers each issued instruction into a 3-deep issue history that feeds the pre-decoder (`LastInstr`, `Last3Instr`). Consumes the pre-decoder's `PC_En`/`instr_sel` to hold the PC and substitute the NOP bubble, and applies branch redirects from execute.

## Interface

Parameters:
- `ISIZE`, 16, instruction width (matches `ISIZE` in `define.v`)
- `ASIZE`, 16, PC / instruction-memory address width, word addressed
- `NOP_INSTR`, 16'h7000, bubble instruction
- `RESET_PC`, 0, PC value after reset

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `PC_En`  in  1  from pre-decoder; 1 = advance PC, 0 = hold PC
- `instr_sel`  in  1  from pre-decoder; 1 = issue `NOP_INSTR` instead of fetched word
- `stall`  in  1  downstream hold; 1 = freeze all fetch state
- `br_taken`  in  1  redirect request from execute
- `br_target`  in  ASIZE  redirect address
- `imem_addr`  out  ASIZE  instruction memory address (= PC register)
- `imem_rdata`  in  ISIZE  instruction word, combinational read of `imem_addr`
- `Instr`  out  ISIZE  current fetched word to pre-decoder (= `imem_rdata`)
- `LastInstr`  out  ISIZE  instruction issued 1 cycle ago (IF/ID register)
- `Last3Instr`  out  ISIZE  instruction issued 3 cycles ago
- `if_id_pc`  out  ASIZE  PC of `LastInstr`
- `bubble_cnt`  out  16  bubbles issued (see Configuration)
- `fetch_cnt`  out  16  real instructions issued (see Configuration)

## Operation

- Issue select, combinational: `issued` = `NOP_INSTR` if `br_taken` or `redirect_pend` or `instr_sel`, else `imem_rdata`. Redirect has priority over `instr_sel`.
- History: hist0 (`LastInstr`), hist1, hist2 (`Last3Instr`). Each non-stalled edge: hist2<=hist1, hist1<=hist0, hist0<=`issued`; `if_id_pc`<=PC.
- Next PC, non-stalled edge:
  - `br_taken` or `redirect_pend` -> saved target
  - else if `PC_En` -> PC+1
  - else -> hold
  - PC+1 wraps modulo 2^ASIZE (16'hFFFF -> 0).
- Redirect during stall:
  - `br_taken`=1 with `stall`=1: capture `br_target` into `redirect_tgt` and set `redirect_pend`.
  - A later `br_taken` during the same stall overwrites the target (newest wins).
  - On the first edge with `stall`=0: PC <= `redirect_tgt`, NOP enters hist0, `redirect_pend` clears.
  - If `br_taken` is also 1 on that edge, live `br_target` wins over `redirect_tgt`.
- `stall`=1: PC, history, `if_id_pc` and counters all hold. Only `redirect_pend`/`redirect_tgt` may update.
- Reset (asynchronous, immediate):
  - PC=`RESET_PC`
  - hist0..hist2=`NOP_INSTR`, never zero: a zero history word would look like a 00-class instruction to the pre-decoder and cause spurious stalls
  - `if_id_pc`=0, `redirect_pend`=0, counters=0
- Reset asserted mid-redirect or mid-stall discards the pending redirect.

## Timing

- `imem_addr` changes only on the clock edge or on reset.
- `Instr` is valid in the same cycle, combinationally from `imem_rdata`.
- Fetch-to-`LastInstr` latency: 1 cycle. Fetch-to-`Last3Instr`: 3 cycles.
- Redirect: `br_taken` in cycle n -> `imem_addr`=target in n+1. The slot issued in n is NOP.
- Pre-decoder stall (`PC_En`=0, `instr_sel`=1) in cycle n -> same `imem_addr` in n+1, NOP in `LastInstr` in n+1.
- No combinational path from `PC_En`/`instr_sel`/`br_taken` to `imem_addr`.

## Configuration

- `FETCH_STATS_EN` defined:
  - `bubble_cnt` increments on each non-stalled edge that issues `NOP_INSTR` because of `instr_sel` or a redirect.
  - `fetch_cnt` increments on each non-stalled edge that issues `imem_rdata`.
  - Both counters saturate at 16'hFFFF and reset to 0.
- `FETCH_STATS_EN` undefined: both ports remain and are tied to 0. No counter flops.

## Test plan

- Reset release with memory 0..3 = 16'h1123,16'h2234,16'h3345,16'h4456 and no hazards -> `imem_addr` 0,1,2,3 on successive cycles; `LastInstr` = 16'h7000 then 16'h1123; `Last3Instr` = 16'h1123 on cycle 4.
- `PC_En`=0, `instr_sel`=1 for one cycle at PC=5 -> PC stays 5 next cycle, `LastInstr`=16'h7000, then fetch resumes at 5 -> 6.
- `br_taken`=1, `br_target`=16'h0040 at PC=8 -> `imem_addr`=16'h0040 next cycle, `LastInstr`=16'h7000, `if_id_pc`=8.
- `stall`=1 for 3 cycles, `br_taken` pulsed with target 16'h0020 in stall cycle 2 -> PC and history frozen; first unstalled edge gives PC=16'h0020 and NOP in hist0.
- PC=16'hFFFF with `PC_En`=1 -> PC=16'h0000. `rst` pulsed mid-cycle -> immediate PC=`RESET_PC`, all history 16'h7000.
- With `FETCH_STATS_EN`: 10 fetches and 2 bubbles -> `fetch_cnt`=10, `bubble_cnt`=2. Without the macro: both read 0.

Source files
------------

// File: rtl/instr_fetch_stage_if.sv
// Fetch-stage bus: instruction memory port, pre-decoder feedback, branch redirect
// and issue-history outputs. The master modport is the fetch stage itself.
interface instr_fetch_stage_if #(
  parameter int unsigned ISIZE = 16,
  parameter int unsigned ASIZE = 16
);
  logic             PC_En;
  logic             instr_sel;
  logic             stall;
  logic             br_taken;
  logic [ASIZE-1:0] br_target;
  logic [ASIZE-1:0] imem_addr;
  logic [ISIZE-1:0] imem_rdata;
  logic [ISIZE-1:0] Instr;
  logic [ISIZE-1:0] LastInstr;
  logic [ISIZE-1:0] Last3Instr;
  logic [ASIZE-1:0] if_id_pc;
  logic [15:0]      bubble_cnt;
  logic [15:0]      fetch_cnt;

  modport master (
    input  PC_En, instr_sel, stall, br_taken, br_target, imem_rdata,
    output imem_addr, Instr, LastInstr, Last3Instr, if_id_pc, bubble_cnt, fetch_cnt
  );

  modport slave (
    output PC_En, instr_sel, stall, br_taken, br_target, imem_rdata,
    input  imem_addr, Instr, LastInstr, Last3Instr, if_id_pc, bubble_cnt, fetch_cnt
  );
endinterface

// File: rtl/instr_fetch_stage.sv
// Fetch stage: PC, NOP-bubble issue select, 3-deep issue history, stall-safe redirect.
// Optional issue statistics counters are built when FETCH_STATS_EN is defined.
module instr_fetch_stage #(
  parameter int unsigned       ISIZE     = 16,
  parameter int unsigned       ASIZE     = 16,
  parameter logic [ISIZE-1:0]  NOP_INSTR = 16'h7000,
  parameter logic [ASIZE-1:0]  RESET_PC  = '0
) (
  input logic                  clk,
  input logic                  rst,
  instr_fetch_stage_if.master  bus
);

  logic [ASIZE-1:0] pc_q, pc_d;
  logic [ASIZE-1:0] if_id_pc_q;
  logic [ISIZE-1:0] hist0_q, hist1_q, hist2_q;
  logic             redirect_pend_q, redirect_pend_d;
  logic [ASIZE-1:0] redirect_tgt_q, redirect_tgt_d;

  logic             redirect;
  logic             issue_nop;
  logic [ISIZE-1:0] issued;
  logic [ASIZE-1:0] redirect_addr;

  // A live branch beats a target parked during a stall (newest wins).
  always_comb begin
    redirect      = bus.br_taken | redirect_pend_q;
    redirect_addr = bus.br_taken ? bus.br_target : redirect_tgt_q;
    issue_nop     = redirect | bus.instr_sel;
    issued        = issue_nop ? NOP_INSTR : bus.imem_rdata;
  end

  always_comb begin
    pc_d            = pc_q;
    redirect_pend_d = redirect_pend_q;
    redirect_tgt_d  = redirect_tgt_q;
    if (bus.stall) begin
      if (bus.br_taken) begin
        redirect_pend_d = 1'b1;
        redirect_tgt_d  = bus.br_target;
      end
    end else begin
      redirect_pend_d = 1'b0;
      if (redirect) begin
        pc_d = redirect_addr;
      end else if (bus.PC_En) begin
        pc_d = pc_q + ASIZE'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_pend_q <= 1'b0;
      redirect_tgt_q  <= '0;
    end else begin
      redirect_pend_q <= redirect_pend_d;
      redirect_tgt_q  <= redirect_tgt_d;
    end
  end

  // History resets to NOP so the pre-decoder never sees a phantom 00-class word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      if_id_pc_q <= '0;
      hist0_q    <= NOP_INSTR;
      hist1_q    <= NOP_INSTR;
      hist2_q    <= NOP_INSTR;
    end else if (!bus.stall) begin
      pc_q       <= pc_d;
      if_id_pc_q <= pc_q;
      hist0_q    <= issued;
      hist1_q    <= hist0_q;
      hist2_q    <= hist1_q;
    end
  end

  assign bus.imem_addr  = pc_q;
  assign bus.Instr      = bus.imem_rdata;
  assign bus.LastInstr  = hist0_q;
  assign bus.Last3Instr = hist2_q;
  assign bus.if_id_pc   = if_id_pc_q;

`ifdef FETCH_STATS_EN
  logic [15:0] bubble_cnt_q;
  logic [15:0] fetch_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt_q <= '0;
      fetch_cnt_q  <= '0;
    end else if (!bus.stall) begin
      if (issue_nop) begin
        if (bubble_cnt_q != '1) bubble_cnt_q <= bubble_cnt_q + 16'd1;
      end else begin
        if (fetch_cnt_q != '1) fetch_cnt_q <= fetch_cnt_q + 16'd1;
      end
    end
  end

  assign bus.bubble_cnt = bubble_cnt_q;
  assign bus.fetch_cnt  = fetch_cnt_q;
`else
  assign bus.bubble_cnt = '0;
  assign bus.fetch_cnt  = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: directed test-plan steps, then randomized traffic
// checked against a behavioural model of PC, issue history and redirects.
module tb_instr_fetch_stage;
  localparam logic [15:0] NOP = 16'h7000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_stage_if #(.ISIZE(16), .ASIZE(16)) bus ();

  instr_fetch_stage #(
    .ISIZE(16), .ASIZE(16), .NOP_INSTR(16'h7000), .RESET_PC(16'h0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0] mem [0:65535];
  assign bus.imem_rdata = mem[bus.imem_addr];

  int passed = 0;
  int total  = 0;

  // Behavioural model state
  int unsigned m_pc;
  logic [15:0] m_hist [3];
  int unsigned m_ifid;
  bit          m_pend;
  int unsigned m_tgt;
  int unsigned m_fetch, m_bub;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_pc = 0; m_ifid = 0; m_pend = 0; m_tgt = 0; m_fetch = 0; m_bub = 0;
    for (int i = 0; i < 3; i++) m_hist[i] = NOP;
  endtask

  task automatic model_edge(input bit pe, input bit sel, input bit st,
                            input bit br, input int unsigned tgt);
    logic [15:0] w;
    if (!st) begin
      if (br || m_pend || sel) begin
        w = NOP;
        if (m_bub < 65535) m_bub++;
      end else begin
        w = mem[m_pc];
        if (m_fetch < 65535) m_fetch++;
      end
      m_hist[2] = m_hist[1];
      m_hist[1] = m_hist[0];
      m_hist[0] = w;
      m_ifid = m_pc;
      if (br)         m_pc = tgt;
      else if (m_pend) m_pc = m_tgt;
      else if (pe)    m_pc = (m_pc + 1) % 65536;
      m_pend = 0;
    end else if (br) begin
      m_pend = 1;
      m_tgt  = tgt;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".imem_addr"},  {16'h0, bus.imem_addr},  m_pc);
    chk({tag, ".Instr"},      {16'h0, bus.Instr},      {16'h0, mem[m_pc]});
    chk({tag, ".LastInstr"},  {16'h0, bus.LastInstr},  {16'h0, m_hist[0]});
    chk({tag, ".Last3Instr"}, {16'h0, bus.Last3Instr}, {16'h0, m_hist[2]});
    chk({tag, ".if_id_pc"},   {16'h0, bus.if_id_pc},   m_ifid);
`ifdef FETCH_STATS_EN
    chk({tag, ".fetch_cnt"},  {16'h0, bus.fetch_cnt},  m_fetch);
    chk({tag, ".bubble_cnt"}, {16'h0, bus.bubble_cnt}, m_bub);
`else
    chk({tag, ".fetch_cnt"},  {16'h0, bus.fetch_cnt},  32'd0);
    chk({tag, ".bubble_cnt"}, {16'h0, bus.bubble_cnt}, 32'd0);
`endif
  endtask

  // Drive inputs, take one clock edge, advance the model, check 1 time unit later.
  task automatic step(input string tag, input bit pe, input bit sel, input bit st,
                      input bit br, input logic [15:0] tgt);
    bus.PC_En     = pe;
    bus.instr_sel = sel;
    bus.stall     = st;
    bus.br_taken  = br;
    bus.br_target = tgt;
    @(posedge clk);
    model_edge(pe, sel, st, br, {16'h0, tgt});
    #1;
    check_all(tag);
  endtask

  // Asynchronous reset pulse in the middle of a cycle.
  task automatic rst_pulse(input string tag);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    chk({tag, ".pc_now"},   {16'h0, bus.imem_addr},  32'd0);
    chk({tag, ".last_nop"}, {16'h0, bus.LastInstr},  {16'h0, NOP});
    chk({tag, ".l3_nop"},   {16'h0, bus.Last3Instr}, {16'h0, NOP});
    #1 rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h1123; mem[1] = 16'h2234; mem[2] = 16'h3345; mem[3] = 16'h4456;
    bus.PC_En = 1'b1; bus.instr_sel = 1'b0; bus.stall = 1'b0;
    bus.br_taken = 1'b0; bus.br_target = '0;
    model_reset();

    // Reset state
    @(posedge clk); #1;
    check_all("reset");
    chk("reset.last", {16'h0, bus.LastInstr}, {16'h0, NOP});
    rst = 1'b0;
    chk("c0.instr", {16'h0, bus.Instr}, 32'h1123);

    // Straight-line fetch
    step("f1", 1, 0, 0, 0, 16'h0);
    chk("f1.addr", {16'h0, bus.imem_addr}, 32'd1);
    chk("f1.last", {16'h0, bus.LastInstr}, 32'h1123);
    step("f2", 1, 0, 0, 0, 16'h0);
    step("f3", 1, 0, 0, 0, 16'h0);
    chk("f3.addr",  {16'h0, bus.imem_addr},  32'd3);
    chk("f3.last3", {16'h0, bus.Last3Instr}, 32'h1123);
    step("f4", 1, 0, 0, 0, 16'h0);
    step("f5", 1, 0, 0, 0, 16'h0);

    // Pre-decoder hold at PC=5
    step("hold", 0, 1, 0, 0, 16'h0);
    chk("hold.addr", {16'h0, bus.imem_addr}, 32'd5);
    chk("hold.last", {16'h0, bus.LastInstr}, {16'h0, NOP});
    step("resume", 1, 0, 0, 0, 16'h0);
    chk("resume.addr", {16'h0, bus.imem_addr}, 32'd6);
    step("f7", 1, 0, 0, 0, 16'h0);
    step("f8", 1, 0, 0, 0, 16'h0);

    // Branch at PC=8
    step("br", 1, 0, 0, 1, 16'h0040);
    chk("br.addr", {16'h0, bus.imem_addr}, 32'h40);
    chk("br.last", {16'h0, bus.LastInstr}, {16'h0, NOP});
    chk("br.ifid", {16'h0, bus.if_id_pc},  32'd8);

    // Redirect captured during a 3-cycle stall
    step("st1", 1, 0, 1, 0, 16'h0);
    step("st2", 1, 0, 1, 1, 16'h0020);
    step("st3", 1, 0, 1, 0, 16'h0);
    chk("st3.addr", {16'h0, bus.imem_addr}, 32'h40);
    step("unst", 1, 0, 0, 0, 16'h0);
    chk("unst.addr", {16'h0, bus.imem_addr}, 32'h20);
    chk("unst.last", {16'h0, bus.LastInstr}, {16'h0, NOP});

    // Stalled redirect overwritten by a newer one, then live branch on release
    step("ow1", 1, 0, 1, 1, 16'h0100);
    step("ow2", 1, 0, 1, 1, 16'h0200);
    step("ow3", 1, 0, 0, 0, 16'h0);
    chk("ow3.addr", {16'h0, bus.imem_addr}, 32'h200);
    step("lv1", 1, 0, 1, 1, 16'h0300);
    step("lv2", 1, 0, 0, 1, 16'h0400);
    chk("lv2.addr", {16'h0, bus.imem_addr}, 32'h400);

    // PC wrap
    step("wr1", 1, 0, 0, 1, 16'hFFFF);
    step("wr2", 1, 0, 0, 0, 16'h0);
    chk("wrap.addr", {16'h0, bus.imem_addr}, 32'd0);
    step("wr3", 1, 0, 0, 0, 16'h0);

    // Async reset mid-cycle, then reset discarding a pending redirect
    rst_pulse("rst_mid");
    step("pr1", 1, 0, 0, 0, 16'h0);
    step("pr2", 1, 0, 1, 1, 16'h0033);
    rst_pulse("rst_pend");
    step("pr3", 1, 0, 0, 0, 16'h0);
    chk("pr3.addr", {16'h0, bus.imem_addr}, 32'd1);

    // 10 fetches and 2 bubbles after a fresh reset
    rst_pulse("rst_cnt");
    for (int i = 0; i < 12; i++) begin
      if (i == 3 || i == 8) step("cnt", 0, 1, 0, 0, 16'h0);
      else                  step("cnt", 1, 0, 0, 0, 16'h0);
    end
`ifdef FETCH_STATS_EN
    chk("cnt.fetch",  {16'h0, bus.fetch_cnt},  32'd10);
    chk("cnt.bubble", {16'h0, bus.bubble_cnt}, 32'd2);
`else
    chk("cnt.fetch",  {16'h0, bus.fetch_cnt},  32'd0);
    chk("cnt.bubble", {16'h0, bus.bubble_cnt}, 32'd0);
`endif

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      bit st, br, sel, pe;
      st  = ($urandom_range(0, 3) == 0);
      br  = ($urandom_range(0, 9) == 0);
      sel = ($urandom_range(0, 4) == 0);
      pe  = sel ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) != 0);
      step("rnd", pe, sel, st, br, 16'($urandom));
      if ($urandom_range(0, 99) == 0) rst_pulse("rnd_rst");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
